fifo_beat_packer: RTL and testbench
===================================

Name: fifo_beat_packer

Overview:
- Downstream consumer of the 19-bit fifo pop side.
- Accepts narrow beats on a valid/ready handshake and packs RATIO consecutive beats into one wide word.
- Presents each wide word on an output valid/ready handshake.
- Sits between the fifo pop port and wide-datapath consumers. Provides full throughput: one beat per cycle in, one word every RATIO cycles out.

Parameters:
- WIDTH, 19, width of one input beat (matches fifo data width).
- RATIO, 4, beats packed per output word; legal range 2..16.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-high reset; rst_n=1 at a rising edge resets all state.
- in_valid  input  1  beat available (driven by fifo pop_valid).
- in_data  input  WIDTH  beat payload (fifo pop_data).
- in_ready  output  1  beat accepted this cycle when in_valid&&in_ready (drives fifo pop_ready).
- out_valid  output  1  packed word available.
- out_data  output  WIDTH*RATIO  packed word; beat 0 (earliest) in bits [WIDTH-1:0], beat k in bits [k*WIDTH +: WIDTH].
- out_ready  input  1  downstream accepts word when out_valid&&out_ready.

Behaviour:
- Reset: out_valid=0, out_data=0, beat counter cnt=0, staging buffer cleared. in_ready=0 in any cycle where rst_n=1; otherwise combinational per the rule below.
- Reset mid-operation: partially collected beats and any unaccepted out word are discarded. No output is produced from them.
- State:
  - cnt (clog2(RATIO) bits, 0..RATIO-1) counts beats held in staging.
  - Staging holds RATIO-1 beats.
  - Output register holds out_data/out_valid.
- FSM is implicit in cnt: COLLECT (cnt<RATIO-1) and LAST (cnt==RATIO-1).
- in_ready = (cnt != RATIO-1) || !out_valid || out_ready.
  - In COLLECT the block always accepts, even while a prior word stalls.
  - In LAST it accepts only when the output register is free or being drained this cycle.
- Accept in COLLECT: staging[cnt] <= in_data; cnt <= cnt+1.
- Accept in LAST:
  - out_data <= {in_data, staging[RATIO-2..0]}; out_valid <= 1; cnt <= 0.
  - Latency: last beat accepted at cycle N gives out_valid=1 at cycle N+1.
- Output drain: out_valid&&out_ready with no simultaneous completing beat sets out_valid <= 0.
- A simultaneous drain and completing beat reloads the register with out_valid staying 1, giving back-to-back words with no bubble.
- Stall: while out_valid&&!out_ready, out_data and out_valid hold stable. No beat may be lost or reordered.
- in_data is ignored when in_valid=0. out_ready is ignored when out_valid=0.
- cnt wraps RATIO-1 -> 0 only on a completing accept; it never increments otherwise.

Optional Feature:
- Macro PACKER_FLUSH_EN.
- Defined:
  - Adds input port flush (1 bit) and output port out_cnt (clog2(RATIO)+1 bits, count of valid beats in out_data).
  - flush=1 with cnt>0 and the output register free or draining emits the partial word: unfilled lanes are zero, out_cnt=cnt (plus 1 if a beat is accepted that same cycle, which is included), and cnt <= 0.
  - flush with cnt==0 and no accepted beat is a no-op.
  - Full words report out_cnt=RATIO.
- Undefined: neither port exists and behaviour is exactly as above.

Test Plan:
- Reset, then in_valid=1 with beats 0x00001, 0x00002, 0x00003, 0x00004 on consecutive cycles, out_ready=1 -> one cycle after the 4th accept, out_valid=1 and out_data=0x00004_00003_00002_00001 (19-bit lanes). in_ready stays 1 throughout.
- Continuous stream of 12 beats with out_ready=1 -> 3 words, one every 4 cycles, no in_ready drop, lanes in order.
- Hold out_ready=0 after the first word, keep feeding -> 3 more beats accepted (cnt=3). The 4th beat sees in_ready=0 and out_data stays stable. Raising out_ready for one cycle drains word 1 and accepts the 4th beat in the same cycle, so word 2 is valid next cycle.
- Assert rst_n=1 for 1 cycle after 2 beats with an unaccepted word pending -> out_valid=0 and cnt=0. Next 4 beats 0x7FFFF each produce out_data of all ones (76 bits); old data never appears.
- Random in_valid/out_ready toggling, 1000 beats with an incrementing payload -> scoreboard matches every lane in order, with no drops or duplicates.
- PACKER_FLUSH_EN: 2 beats 0x00011, 0x00022 then flush=1 -> out_data=0x00000_00000_00022_00011, out_cnt=2, cnt returns to 0.

Source files
------------

// File: rtl/fifo_beat_packer_if.sv
// Narrow-beat in / wide-word out handshake bundle for fifo_beat_packer.
// PACKER_FLUSH_EN adds the flush request and the out_cnt lane count.
interface fifo_beat_packer_if #(
  parameter int WIDTH = 19,
  parameter int RATIO = 4
);
  logic                     in_valid;
  logic [WIDTH-1:0]         in_data;
  logic                     in_ready;
  logic                     out_valid;
  logic [WIDTH*RATIO-1:0]   out_data;
  logic                     out_ready;
`ifdef PACKER_FLUSH_EN
  logic                     flush;
  logic [$clog2(RATIO):0]   out_cnt;

  modport master (
    output in_valid, in_data, out_ready, flush,
    input  in_ready, out_valid, out_data, out_cnt
  );
  modport slave (
    input  in_valid, in_data, out_ready, flush,
    output in_ready, out_valid, out_data, out_cnt
  );
`else
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
`endif
endinterface

// File: rtl/fifo_beat_packer.sv
// Packs RATIO narrow beats into one wide word at full throughput.
// Optional partial-word flush and lane count when PACKER_FLUSH_EN is defined.
module fifo_beat_packer #(
  parameter int WIDTH = 19,
  parameter int RATIO = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  fifo_beat_packer_if.slave bus
);
  localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int OCW   = CNT_W + 1;

  logic [CNT_W-1:0]       cnt;
  logic [WIDTH-1:0]       stage_p0 [RATIO-1];
  logic [WIDTH*RATIO-1:0] word_p0;
  logic [WIDTH*RATIO-1:0] data_p1;
  logic                   vld_p1;

  logic last;
  logic in_ready;
  logic accept;
  logic complete;
  logic drain;
  logic emit;

  assign last     = (cnt == CNT_W'(RATIO - 1));
  assign drain    = vld_p1 && bus.out_ready;
  // Rejects only when the final beat would have nowhere to go.
  assign in_ready = !rst_n && (!last || !vld_p1 || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;
  assign complete = accept && last;

`ifdef PACKER_FLUSH_EN
  logic [OCW-1:0] cnt_p1;

  assign emit = complete ||
                (bus.flush && (!vld_p1 || bus.out_ready) && ((cnt != '0) || accept));
  assign bus.out_cnt = cnt_p1;
`else
  assign emit = complete;
`endif

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = vld_p1;
  assign bus.out_data  = data_p1;

  // Stage 0: assemble staged lanes plus the beat arriving now; unfilled lanes stay zero.
  always_comb begin
    word_p0 = '0;
    for (int k = 0; k < RATIO - 1; k++) begin
      if (k < int'(cnt)) word_p0[k*WIDTH +: WIDTH] = stage_p0[k];
    end
    for (int k = 0; k < RATIO; k++) begin
      if (accept && (k == int'(cnt))) word_p0[k*WIDTH +: WIDTH] = bus.in_data;
    end
  end

  // Stage 1: output word register.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      cnt     <= '0;
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      for (int k = 0; k < RATIO - 1; k++) stage_p0[k] <= '0;
`ifdef PACKER_FLUSH_EN
      cnt_p1  <= '0;
`endif
    end else if (emit) begin
      data_p1 <= word_p0;
      vld_p1  <= 1'b1;
      cnt     <= '0;
`ifdef PACKER_FLUSH_EN
      cnt_p1  <= complete ? OCW'(RATIO) : (OCW'(cnt) + OCW'(accept));
`endif
    end else begin
      if (drain) vld_p1 <= 1'b0;
      if (accept) begin
        stage_p0[cnt] <= bus.in_data;
        cnt           <= cnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_fifo_beat_packer.sv
// Self-checking bench for fifo_beat_packer: directed table, corner sequences, random stream vs beat-queue model.
// Exercises the partial-word flush when PACKER_FLUSH_EN is defined.
module tb_fifo_beat_packer;
  localparam int W = 19;
  localparam int R = 4;
  localparam int WW = W * R;

  typedef logic [W-1:0]  beat_t;
  typedef logic [WW-1:0] word_t;

  typedef struct {
    logic  iv;
    beat_t d;
    logic  ordy;
    logic  exp_ir;
    logic  exp_ov;
    word_t exp_od;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  beat_t beats[$];
  word_t words[$];
  int    cntq[$];
  int    drained = 0;
  logic  last_acc;

  fifo_beat_packer_if #(.WIDTH(W), .RATIO(R)) bus ();

  fifo_beat_packer #(.WIDTH(W), .RATIO(R)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic void chk1(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void chkw(string name, word_t act, word_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void chki(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic word_t pack(input beat_t q[$]);
    word_t w = '0;
    for (int i = 0; i < q.size(); i++) w[i*W +: W] = q[i];
    return w;
  endfunction

  // One clock: check against the model at negedge, advance the model, return #1 after posedge.
  task automatic step();
    logic exp_ir, acc, drn, free;
    @(negedge clk);
    if (rst_n) exp_ir = 1'b0;
    else exp_ir = !((beats.size() == R - 1) && (words.size() > 0) && !bus.out_ready);
    chk1("model_in_ready", bus.in_ready, exp_ir);
    if (!rst_n) begin
      chk1("model_out_valid", bus.out_valid, words.size() > 0);
      if (words.size() > 0) begin
        chkw("model_out_data", bus.out_data, words[0]);
`ifdef PACKER_FLUSH_EN
        chki("model_out_cnt", int'(bus.out_cnt), cntq[0]);
`endif
      end
    end
    acc  = bus.in_valid && exp_ir;
    drn  = (words.size() > 0) && bus.out_ready && !rst_n;
    free = (words.size() == 0) || drn;
    last_acc = acc;
    if (rst_n) begin
      beats.delete();
      words.delete();
      cntq.delete();
    end else begin
      if (drn) begin
        void'(words.pop_front());
        void'(cntq.pop_front());
        drained++;
      end
      if (acc) beats.push_back(bus.in_data);
      if (beats.size() == R) begin
        words.push_back(pack(beats));
        cntq.push_back(R);
        beats.delete();
      end
`ifdef PACKER_FLUSH_EN
      else if (bus.flush && free && beats.size() > 0) begin
        words.push_back(pack(beats));
        cntq.push_back(beats.size());
        beats.delete();
      end
`endif
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic iv, beat_t d, logic ordy);
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.out_ready = ordy;
  endtask

  task automatic do_reset();
    rst_n = 1'b1;
    drive(1'b0, '0, 1'b0);
    step();
    step();
    rst_n = 1'b0;
  endtask

  vec_t  tbl[13];
  word_t w1, w2;
  int    base;
  int    sent;
  int    cyc;
  beat_t payload;

  initial begin
    rst_n = 1'b1;
    drive(1'b0, '0, 1'b0);
`ifdef PACKER_FLUSH_EN
    bus.flush = 1'b0;
`endif
    #1;

    w1 = {19'h00004, 19'h00003, 19'h00002, 19'h00001};
    w2 = {19'h00008, 19'h00007, 19'h00006, 19'h00005};
    tbl[0]  = '{1'b1, 19'h1, 1'b1, 1'b1, 1'b0, '0};
    tbl[1]  = '{1'b1, 19'h2, 1'b1, 1'b1, 1'b0, '0};
    tbl[2]  = '{1'b1, 19'h3, 1'b1, 1'b1, 1'b0, '0};
    tbl[3]  = '{1'b1, 19'h4, 1'b1, 1'b1, 1'b0, '0};
    tbl[4]  = '{1'b1, 19'h5, 1'b0, 1'b1, 1'b1, w1};
    tbl[5]  = '{1'b1, 19'h6, 1'b0, 1'b1, 1'b1, w1};
    tbl[6]  = '{1'b1, 19'h7, 1'b0, 1'b1, 1'b1, w1};
    tbl[7]  = '{1'b1, 19'h8, 1'b0, 1'b0, 1'b1, w1};
    tbl[8]  = '{1'b1, 19'h8, 1'b0, 1'b0, 1'b1, w1};
    tbl[9]  = '{1'b1, 19'h8, 1'b1, 1'b1, 1'b1, w1};
    tbl[10] = '{1'b0, 19'h0, 1'b0, 1'b1, 1'b1, w2};
    tbl[11] = '{1'b0, 19'h0, 1'b1, 1'b1, 1'b1, w2};
    tbl[12] = '{1'b0, 19'h0, 1'b0, 1'b1, 1'b0, '0};

    // Reset state
    do_reset();
    chk1("reset_out_valid", bus.out_valid, 1'b0);
    chkw("reset_out_data", bus.out_data, '0);

    // Directed first word, then stall and same-cycle drain+complete
    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].iv, tbl[i].d, tbl[i].ordy);
      #1;
      chk1($sformatf("tbl%0d_in_ready", i), bus.in_ready, tbl[i].exp_ir);
      chk1($sformatf("tbl%0d_out_valid", i), bus.out_valid, tbl[i].exp_ov);
      if (tbl[i].exp_ov) chkw($sformatf("tbl%0d_out_data", i), bus.out_data, tbl[i].exp_od);
      step();
    end

    // Continuous 12-beat stream
    base = drained;
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, beat_t'(32'h100 + i), 1'b1);
      step();
    end
    drive(1'b0, '0, 1'b1);
    step();
    step();
    chki("stream_words", drained - base, 3);

    // Reset mid-operation with a pending word and 2 staged beats
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, beat_t'(32'h200 + i), 1'b0);
      step();
    end
    chk1("pre_reset_out_valid", bus.out_valid, 1'b1);
    rst_n = 1'b1;
    drive(1'b0, '0, 1'b0);
    step();
    rst_n = 1'b0;
    chk1("midreset_out_valid", bus.out_valid, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 19'h7FFFF, 1'b1);
      step();
    end
    drive(1'b0, '0, 1'b1);
    chk1("ones_out_valid", bus.out_valid, 1'b1);
    chkw("ones_out_data", bus.out_data, {WW{1'b1}});
    step();

    // Random handshake stream with incrementing payload
    base = drained;
    sent = 0;
    cyc = 0;
    payload = 19'h1;
    while (sent < 1000 && cyc < 20000) begin
      drive(($urandom_range(0, 3) != 0), payload, ($urandom_range(0, 1) == 1));
      step();
      if (last_acc) begin
        sent++;
        payload = payload + 19'h1;
      end
      cyc++;
    end
    chki("random_beats_sent", sent, 1000);
    drive(1'b0, '0, 1'b1);
    for (int i = 0; i < 4; i++) step();
    chki("random_words", drained - base, 250);

`ifdef PACKER_FLUSH_EN
    do_reset();
    drive(1'b1, 19'h00011, 1'b1);
    step();
    drive(1'b1, 19'h00022, 1'b1);
    step();
    drive(1'b0, '0, 1'b0);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    chk1("flush_out_valid", bus.out_valid, 1'b1);
    chkw("flush_out_data", bus.out_data, {19'h0, 19'h0, 19'h00022, 19'h00011});
    chki("flush_out_cnt", int'(bus.out_cnt), 2);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, beat_t'(32'h300 + i), 1'b1);
      step();
    end
    drive(1'b0, '0, 1'b1);
    chkw("post_flush_data", bus.out_data, {19'h00303, 19'h00302, 19'h00301, 19'h00300});
    chki("post_flush_cnt", int'(bus.out_cnt), R);
    step();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
